// File: rtl/jtag_vdr_io_if.sv
// Virtual JTAG hub / user I/O bundle for jtag_vdr_io.
// master = hub and user-logic side, slave = the data-register block.
interface jtag_vdr_io_if #(
   parameter int DR_WIDTH = 8,
   parameter int IR_WIDTH = 2
);
   logic                tdi;
   logic [IR_WIDTH-1:0] ir_in;
   logic                v_cdr;
   logic                v_sdr;
   logic                udr;
   logic [DR_WIDTH-1:0] din;
   logic [DR_WIDTH-1:0] dout;
   logic                dout_valid;
   logic                tdo;

   modport master (
      output tdi, ir_in, v_cdr, v_sdr, udr, din,
      input  dout, dout_valid, tdo
   );

   modport slave (
      input  tdi, ir_in, v_cdr, v_sdr, udr, din,
      output dout, dout_valid, tdo
   );
endinterface

// File: rtl/jtag_vdr_io.sv
// Virtual-JTAG data register: BYPASS/WRITE/READ/STATUS on a multi-bit IR, all on tck.
// Define JTAG_VDR_READBACK_EN to capture the current dout on WRITE (read-modify-write scan).
module jtag_vdr_io #(
   parameter int                  DR_WIDTH  = 8,
   parameter int                  IR_WIDTH  = 2,
   parameter logic [DR_WIDTH-1:0] RESET_VAL = '0
) (
   input logic           tck,
   input logic           aclr,
   jtag_vdr_io_if.slave  bus
);

   typedef enum logic [1:0] {
      OP_BYPASS = 2'd0,
      OP_WRITE  = 2'd1,
      OP_READ   = 2'd2,
      OP_STATUS = 2'd3
   } op_e;

   localparam logic [IR_WIDTH-1:0] IR_WRITE  = IR_WIDTH'(1);
   localparam logic [IR_WIDTH-1:0] IR_READ   = IR_WIDTH'(2);
   localparam logic [IR_WIDTH-1:0] IR_STATUS = IR_WIDTH'(3);

   op_e                 op;
   logic                bypass_q;
   logic                udr_q;
   logic                upd_edge;
   logic                dout_valid_q;
   logic [DR_WIDTH-1:0] sr;
   logic [DR_WIDTH-1:0] cap_val;
   logic [DR_WIDTH-1:0] dout_q;
   logic [DR_WIDTH-1:0] upd_cnt;

   // Unused codes (including anything >= 4) fall back to BYPASS.
   always_comb begin
      op = OP_BYPASS;
      if (bus.ir_in == IR_WRITE)       op = OP_WRITE;
      else if (bus.ir_in == IR_READ)   op = OP_READ;
      else if (bus.ir_in == IR_STATUS) op = OP_STATUS;
   end

   always_comb begin
      cap_val = '0;
      case (op)
         OP_READ:   cap_val = bus.din;
         OP_STATUS: cap_val = upd_cnt;
`ifdef JTAG_VDR_READBACK_EN
         OP_WRITE:  cap_val = dout_q;
`else
         OP_WRITE:  cap_val = '0;
`endif
         default:   cap_val = '0;
      endcase
   end

   assign upd_edge = bus.udr & ~udr_q;

   always_ff @(posedge tck) begin
      if (aclr) begin
         bypass_q     <= 1'b0;
         udr_q        <= 1'b0;
         sr           <= '0;
         dout_q       <= RESET_VAL;
         dout_valid_q <= 1'b0;
         upd_cnt      <= '0;
      end else begin
         bypass_q     <= bus.tdi;
         udr_q        <= bus.udr;
         dout_valid_q <= 1'b0;
         // Capture takes priority when the hub asserts both states together.
         if (op != OP_BYPASS) begin
            if (bus.v_cdr)      sr <= cap_val;
            else if (bus.v_sdr) sr <= {bus.tdi, sr[DR_WIDTH-1:1]};
         end
         if (upd_edge && op == OP_WRITE) begin
            dout_q       <= sr;
            dout_valid_q <= 1'b1;
            upd_cnt      <= upd_cnt + 1'b1;
         end
      end
   end

   assign bus.tdo        = (op == OP_BYPASS) ? bypass_q : sr[0];
   assign bus.dout       = dout_q;
   assign bus.dout_valid = dout_valid_q;

endmodule

// File: tb/tb_jtag_vdr_io.sv
// Directed bench for jtag_vdr_io: bypass, reset, write/read/status scans, counter wrap, readback.
module tb_jtag_vdr_io;
   localparam int DR = 8;
   localparam int IR = 3;

   logic tck = 1'b0;
   logic aclr;
   int   checks = 0;
   int   failures = 0;

   jtag_vdr_io_if #(.DR_WIDTH(DR), .IR_WIDTH(IR)) bus ();

   jtag_vdr_io #(.DR_WIDTH(DR), .IR_WIDTH(IR), .RESET_VAL(8'h00)) dut (
      .tck  (tck),
      .aclr (aclr),
      .bus  (bus)
   );

   always #5 tck = ~tck;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge tck);
      #1;
   endtask

   // Capture then shift DR bits LSB first; returns the bits seen on tdo.
   task automatic scan(input logic [IR-1:0] ir, input logic [DR-1:0] din_bits,
                       output logic [DR-1:0] dout_bits);
      bus.ir_in = ir;
      bus.v_cdr = 1'b1;
      tick();
      bus.v_cdr = 1'b0;
      bus.v_sdr = 1'b1;
      for (int i = 0; i < DR; i++) begin
         dout_bits[i] = bus.tdo;
         bus.tdi = din_bits[i];
         tick();
      end
      bus.v_sdr = 1'b0;
      bus.tdi = 1'b0;
   endtask

   // Hold udr for three cycles; check the single-update behaviour.
   task automatic upd(input string tag, input logic [IR-1:0] ir, input logic wr,
                      input logic [DR-1:0] exp_dout);
      bus.ir_in = ir;
      bus.udr = 1'b1;
      tick();
      chk({tag, "_dout"}, 32'(bus.dout), 32'(exp_dout));
      chk({tag, "_vld1"}, 32'(bus.dout_valid), 32'(wr));
      tick();
      chk({tag, "_vld2"}, 32'(bus.dout_valid), 32'd0);
      tick();
      chk({tag, "_hold"}, 32'(bus.dout), 32'(exp_dout));
      bus.udr = 1'b0;
      tick();
   endtask

   logic [DR-1:0] so;
   logic [3:0]    bpat;

   initial begin
      aclr = 1'b1;
      bus.tdi = 1'b0; bus.ir_in = '0; bus.v_cdr = 1'b0; bus.v_sdr = 1'b0;
      bus.udr = 1'b0; bus.din = '0;
      tick(); tick();
      aclr = 1'b0;
      tick();
      chk("rst_dout", 32'(bus.dout), 32'h00);
      chk("rst_vld", 32'(bus.dout_valid), 32'd0);
      chk("rst_tdo", 32'(bus.tdo), 32'd0);

      // Bypass: tdo is tdi delayed one tck
      bpat = 4'b1101;
      for (int i = 0; i < 4; i++) begin
         bus.tdi = bpat[i];
         tick();
         chk("bypass_tdo", 32'(bus.tdo), 32'(bpat[i]));
      end
      bus.tdi = 1'b0;

      // Reset mid-shift discards the partial scan
      scan(3'd1, 8'hFF, so);
      chk("pre_rst_tdo", 32'(bus.tdo), 32'd1);
      bus.v_sdr = 1'b1;
      bus.tdi = 1'b1;
      tick();
      aclr = 1'b1;
      bus.v_sdr = 1'b0;
      bus.tdi = 1'b0;
      tick();
      aclr = 1'b0;
      tick();
      chk("midrst_sr", 32'(bus.tdo), 32'd0);
      bus.udr = 1'b1; tick();
      chk("midrst_dout", 32'(bus.dout), 32'h00);
      bus.udr = 1'b0; tick();
      aclr = 1'b1; tick(); aclr = 1'b0; tick();

      // WRITE A5
      scan(3'd1, 8'hA5, so);
      chk("wr_a5_so", 32'(so), 32'h00);
      upd("wr_a5", 3'd1, 1'b1, 8'hA5);
      scan(3'd3, 8'h00, so);
      chk("status1", 32'(so), 32'h01);
      chk("status_dout", 32'(bus.dout), 32'hA5);

      // READ 3C
      bus.din = 8'h3C;
      scan(3'd2, 8'hFF, so);
      chk("read_3c", 32'(so), 32'h3C);
      chk("read_dout", 32'(bus.dout), 32'hA5);

      // Readback WRITE scan
      scan(3'd1, 8'h0F, so);
`ifdef JTAG_VDR_READBACK_EN
      chk("readback_so", 32'(so), 32'hA5);
`else
      chk("readback_so", 32'(so), 32'h00);
`endif
      upd("wr_0f", 3'd1, 1'b1, 8'h0F);

      // udr edges outside WRITE do nothing
      upd("udr_read", 3'd2, 1'b0, 8'h0F);
      upd("udr_ir5", 3'd5, 1'b0, 8'h0F);

      // Capture beats shift; then shift out the full captured word
      bus.din = 8'h5A;
      bus.ir_in = 3'd2;
      bus.v_cdr = 1'b1; bus.v_sdr = 1'b1; bus.tdi = 1'b1;
      tick();
      chk("cdr_sdr_tdo", 32'(bus.tdo), 32'd0);
      bus.v_cdr = 1'b0;
      for (int i = 0; i < DR; i++) begin
         so[i] = bus.tdo;
         bus.tdi = 1'b0;
         tick();
      end
      bus.v_sdr = 1'b0;
      chk("cdr_sdr_word", 32'(so), 32'h5A);

      // Counter wrap after 256 updates
      aclr = 1'b1; tick(); aclr = 1'b0; tick();
      bus.ir_in = 3'd1;
      for (int i = 0; i < 256; i++) begin
         bus.udr = 1'b1; tick();
         bus.udr = 1'b0; tick();
      end
      scan(3'd3, 8'h00, so);
      chk("cnt_wrap", 32'(so), 32'h00);
      bus.ir_in = 3'd1;
      bus.udr = 1'b1; tick();
      bus.udr = 1'b0; tick();
      scan(3'd3, 8'h00, so);
      chk("cnt_after_wrap", 32'(so), 32'h01);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
